// File: rtl/pcsel_decoder_if.sv
// Bus bundle between the hazard priority encoder (master) and pcsel_decoder (slave).
// PCSEL_STATS_EN adds the redirect_cnt observation signal.
interface pcsel_decoder_if #(
   parameter int AW = 8
);
   logic [4:0]    sel;
   logic [AW-1:0] tgt_a;
   logic [AW-1:0] tgt_b;
   logic [AW-1:0] tgt_c;
   logic [AW-1:0] tgt_d;
   logic          stall;
   logic [AW-1:0] pc;
   logic          flush;
   logic [2:0]    src_idx;
   logic          sel_err;
   logic          pend_vld;
`ifdef PCSEL_STATS_EN
   logic [15:0]   redirect_cnt;

   modport master (output sel, tgt_a, tgt_b, tgt_c, tgt_d, stall,
                   input  pc, flush, src_idx, sel_err, pend_vld, redirect_cnt);
   modport slave  (input  sel, tgt_a, tgt_b, tgt_c, tgt_d, stall,
                   output pc, flush, src_idx, sel_err, pend_vld, redirect_cnt);
`else
   modport master (output sel, tgt_a, tgt_b, tgt_c, tgt_d, stall,
                   input  pc, flush, src_idx, sel_err, pend_vld);
   modport slave  (input  sel, tgt_a, tgt_b, tgt_c, tgt_d, stall,
                   output pc, flush, src_idx, sel_err, pend_vld);
`endif
endinterface

// File: rtl/pcsel_decoder.sv
// Next-PC select decoder: owns the PC, sequences post-redirect flush, buffers stalled redirects.
// Optional macro PCSEL_STATS_EN adds a saturating 16-bit applied-redirect counter.
module pcsel_decoder #(
   parameter int            AW           = 8,
   parameter int            FLUSH_CYCLES = 2,
   parameter logic [AW-1:0] RESET_PC     = '0
) (
   input logic           clk,
   input logic           rst,
   pcsel_decoder_if.slave bus
);
   localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   state_t        state_q, state_n;
   logic [AW-1:0] pc_q, pc_n;
   logic [2:0]    src_q, src_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic          pend_vld_q, pend_vld_n;
   logic [AW-1:0] pend_tgt_q, pend_tgt_n;
   logic [2:0]    pend_src_q, pend_src_n;
   logic          flush_q, sel_err_q;

   logic          redir, illegal, apply;
   logic [2:0]    dec_src, app_src;
   logic [AW-1:0] dec_tgt, app_tgt;

   // Illegal codes decode as sequential; they only raise sel_err.
   always_comb begin
      redir   = 1'b0;
      illegal = 1'b0;
      dec_src = 3'd0;
      dec_tgt = bus.tgt_a;
      case (bus.sel)
         5'b00000: ;
         5'b00010: begin redir = 1'b1; dec_src = 3'd1; dec_tgt = bus.tgt_a; end
         5'b00100: begin redir = 1'b1; dec_src = 3'd2; dec_tgt = bus.tgt_b; end
         5'b01000: begin redir = 1'b1; dec_src = 3'd3; dec_tgt = bus.tgt_c; end
         5'b10000: begin redir = 1'b1; dec_src = 3'd4; dec_tgt = bus.tgt_d; end
         default:  illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_n    = state_q;
      pc_n       = pc_q;
      src_n      = src_q;
      cnt_n      = cnt_q;
      pend_vld_n = pend_vld_q;
      pend_tgt_n = pend_tgt_q;
      pend_src_n = pend_src_q;
      apply      = 1'b0;
      app_src    = dec_src;
      app_tgt    = dec_tgt;
      case (state_q)
         RUN: begin
            if (bus.stall) begin
               if (redir) begin
                  pend_vld_n = 1'b1;
                  pend_tgt_n = dec_tgt;
                  pend_src_n = dec_src;
               end
               state_n = STALL;
            end else if (redir) begin
               apply = 1'b1;
            end else begin
               pc_n  = pc_q + 1'b1;
               src_n = 3'd0;
            end
         end
         STALL: begin
            if (bus.stall) begin
               if (redir) begin
                  pend_vld_n = 1'b1;
                  pend_tgt_n = dec_tgt;
                  pend_src_n = dec_src;
               end
            end else if (redir) begin
               apply = 1'b1;
            end else if (pend_vld_q) begin
               apply   = 1'b1;
               app_src = pend_src_q;
               app_tgt = pend_tgt_q;
            end else begin
               pc_n    = pc_q + 1'b1;
               src_n   = 3'd0;
               state_n = RUN;
            end
         end
         FLUSH: begin
            if (!bus.stall) begin
               pc_n  = pc_q + 1'b1;
               src_n = 3'd0;
               if (cnt_q <= CW'(1)) state_n = RUN;
               else                 cnt_n   = cnt_q - CW'(1);
            end
         end
         default: state_n = RUN;
      endcase
      // Any applied redirect, live or buffered, lands here so both paths stay identical.
      if (apply) begin
         pc_n       = app_tgt;
         src_n      = app_src;
         pend_vld_n = 1'b0;
         cnt_n      = CW'(FLUSH_CYCLES);
         state_n    = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         src_q      <= 3'd0;
         cnt_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_tgt_q <= '0;
         pend_src_q <= 3'd0;
         flush_q    <= 1'b0;
         sel_err_q  <= 1'b0;
      end else begin
         state_q    <= state_n;
         pc_q       <= pc_n;
         src_q      <= src_n;
         cnt_q      <= cnt_n;
         pend_vld_q <= pend_vld_n;
         pend_tgt_q <= pend_tgt_n;
         pend_src_q <= pend_src_n;
         flush_q    <= (state_n == FLUSH);
         sel_err_q  <= illegal;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.flush    = flush_q;
   assign bus.src_idx  = src_q;
   assign bus.sel_err  = sel_err_q;
   assign bus.pend_vld = pend_vld_q;

`ifdef PCSEL_STATS_EN
   logic [15:0] rcnt_q;

   always_ff @(posedge clk) begin
      if (rst)                        rcnt_q <= '0;
      else if (apply && rcnt_q != '1) rcnt_q <= rcnt_q + 16'd1;
   end

   assign bus.redirect_cnt = rcnt_q;
`endif
endmodule

// File: tb/tb_pcsel_decoder.sv
// Scoreboard bench for pcsel_decoder: rows of stimulus plus hand-derived expectations.
module tb_pcsel_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pcsel_decoder_if #(.AW(8)) bus ();

   pcsel_decoder #(.AW(8), .FLUSH_CYCLES(2), .RESET_PC(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic        rst;
      logic [4:0]  sel;
      logic        stall;
      logic [7:0]  tgt;
      logic [7:0]  pc;
      logic        flush;
      logic [2:0]  src;
      logic        err;
      logic        pend;
      logic [15:0] cnt;
   } row_t;

   row_t stim_q[$];
   row_t exp_q[$];
   row_t r, e;

   task automatic put(input logic rs, input logic [4:0] s, input logic st, input logic [7:0] t,
                      input logic [7:0] p, input logic f, input logic [2:0] si,
                      input logic er, input logic pv, input logic [15:0] c = 16'd0);
      row_t x;
      x = '{rst: rs, sel: s, stall: st, tgt: t, pc: p, flush: f, src: si, err: er, pend: pv, cnt: c};
      stim_q.push_back(x);
   endtask

   // Only the selected source sees the row target; the others carry distinct junk.
   task automatic drive(input row_t x);
      rst       = x.rst;
      bus.sel   = x.sel;
      bus.stall = x.stall;
      bus.tgt_a = x.sel[1] ? x.tgt : 8'hA5;
      bus.tgt_b = x.sel[2] ? x.tgt : 8'hB6;
      bus.tgt_c = x.sel[3] ? x.tgt : 8'hC7;
      bus.tgt_d = x.sel[4] ? x.tgt : 8'hD8;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      put(1, 5'b00011, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h01, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h02, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h03, 0, 0, 0, 0);
      for (int i = 0; stim_q.size() > 0; i++) begin
         r = stim_q.pop_front(); drive(r); e = exp_q.pop_front(); checks++;
         if ({bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld} !== {e.pc, e.flush, e.src, e.err, e.pend}) begin
            errors++;
            $display("FAIL reset[%0d]: got pc=%h flush=%b src=%0d err=%b pend=%b, expected pc=%h flush=%b src=%0d err=%b pend=%b",
                     i, bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld, e.pc, e.flush, e.src, e.err, e.pend);
         end
      end
   endtask

   task automatic test_redirect();
      put(1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      for (int k = 1; k <= 16; k++) put(0, 5'b00000, 0, 8'h00, 8'(k), 0, 0, 0, 0);
      put(0, 5'b01000, 0, 8'h40, 8'h40, 1, 3, 0, 0);
      put(0, 5'b00010, 0, 8'h99, 8'h41, 1, 0, 0, 0);
      put(0, 5'b00010, 0, 8'h99, 8'h42, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h43, 0, 0, 0, 0);
      for (int i = 0; stim_q.size() > 0; i++) begin
         r = stim_q.pop_front(); drive(r); e = exp_q.pop_front(); checks++;
         if ({bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld} !== {e.pc, e.flush, e.src, e.err, e.pend}) begin
            errors++;
            $display("FAIL redirect[%0d]: got pc=%h flush=%b src=%0d err=%b pend=%b, expected pc=%h flush=%b src=%0d err=%b pend=%b",
                     i, bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld, e.pc, e.flush, e.src, e.err, e.pend);
         end
      end
   endtask

   task automatic test_stall_pending();
      put(1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      put(0, 5'b00100, 1, 8'h20, 8'h00, 0, 0, 0, 1);
      put(0, 5'b10000, 1, 8'h30, 8'h00, 0, 0, 0, 1);
      put(0, 5'b00000, 0, 8'h00, 8'h30, 1, 4, 0, 0);
      put(0, 5'b00000, 1, 8'h00, 8'h30, 1, 4, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h31, 1, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h32, 0, 0, 0, 0);
      put(0, 5'b00100, 1, 8'h20, 8'h32, 0, 0, 0, 1);
      put(0, 5'b01000, 0, 8'h77, 8'h77, 1, 3, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h78, 1, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h79, 0, 0, 0, 0);
      put(0, 5'b00000, 1, 8'h00, 8'h79, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h7A, 0, 0, 0, 0);
      for (int i = 0; stim_q.size() > 0; i++) begin
         r = stim_q.pop_front(); drive(r); e = exp_q.pop_front(); checks++;
         if ({bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld} !== {e.pc, e.flush, e.src, e.err, e.pend}) begin
            errors++;
            $display("FAIL stall_pending[%0d]: got pc=%h flush=%b src=%0d err=%b pend=%b, expected pc=%h flush=%b src=%0d err=%b pend=%b",
                     i, bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld, e.pc, e.flush, e.src, e.err, e.pend);
         end
      end
   endtask

   task automatic test_illegal();
      put(1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      put(0, 5'b00011, 0, 8'h00, 8'h01, 0, 0, 1, 0);
      put(0, 5'b11000, 0, 8'h00, 8'h02, 0, 0, 1, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h03, 0, 0, 0, 0);
      put(0, 5'b00001, 1, 8'h00, 8'h03, 0, 0, 1, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h04, 0, 0, 0, 0);
      put(0, 5'b00010, 0, 8'h50, 8'h50, 1, 1, 0, 0);
      put(0, 5'b10100, 0, 8'h00, 8'h51, 1, 0, 1, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h52, 0, 0, 0, 0);
      for (int i = 0; stim_q.size() > 0; i++) begin
         r = stim_q.pop_front(); drive(r); e = exp_q.pop_front(); checks++;
         if ({bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld} !== {e.pc, e.flush, e.src, e.err, e.pend}) begin
            errors++;
            $display("FAIL illegal[%0d]: got pc=%h flush=%b src=%0d err=%b pend=%b, expected pc=%h flush=%b src=%0d err=%b pend=%b",
                     i, bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld, e.pc, e.flush, e.src, e.err, e.pend);
         end
      end
   endtask

   task automatic test_wrap();
      put(1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      put(0, 5'b10000, 0, 8'hFE, 8'hFE, 1, 4, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'hFF, 1, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      put(0, 5'b00010, 0, 8'hFD, 8'hFD, 1, 1, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'hFE, 1, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'hFF, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      for (int i = 0; stim_q.size() > 0; i++) begin
         r = stim_q.pop_front(); drive(r); e = exp_q.pop_front(); checks++;
         if ({bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld} !== {e.pc, e.flush, e.src, e.err, e.pend}) begin
            errors++;
            $display("FAIL wrap[%0d]: got pc=%h flush=%b src=%0d err=%b pend=%b, expected pc=%h flush=%b src=%0d err=%b pend=%b",
                     i, bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld, e.pc, e.flush, e.src, e.err, e.pend);
         end
      end
   endtask

   task automatic test_reset_mid();
      put(1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      put(0, 5'b00010, 1, 8'h11, 8'h00, 0, 0, 0, 1);
      put(1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h01, 0, 0, 0, 0);
      put(0, 5'b01000, 0, 8'h60, 8'h60, 1, 3, 0, 0);
      put(1, 5'b00010, 0, 8'h44, 8'h00, 0, 0, 0, 0);
      put(0, 5'b00000, 0, 8'h00, 8'h01, 0, 0, 0, 0);
      for (int i = 0; stim_q.size() > 0; i++) begin
         r = stim_q.pop_front(); drive(r); e = exp_q.pop_front(); checks++;
         if ({bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld} !== {e.pc, e.flush, e.src, e.err, e.pend}) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got pc=%h flush=%b src=%0d err=%b pend=%b, expected pc=%h flush=%b src=%0d err=%b pend=%b",
                     i, bus.pc, bus.flush, bus.src_idx, bus.sel_err, bus.pend_vld, e.pc, e.flush, e.src, e.err, e.pend);
         end
      end
   endtask

`ifdef PCSEL_STATS_EN
   task automatic test_stats();
      put(1, 5'b00000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 16'd0);
      put(0, 5'b01000, 0, 8'h40, 8'h40, 1, 3, 0, 0, 16'd1);
      put(0, 5'b00010, 0, 8'h99, 8'h41, 1, 0, 0, 0, 16'd1);
      put(0, 5'b00000, 0, 8'h00, 8'h42, 0, 0, 0, 0, 16'd1);
      put(0, 5'b00100, 1, 8'h20, 8'h42, 0, 0, 0, 1, 16'd1);
      put(0, 5'b00000, 0, 8'h00, 8'h20, 1, 2, 0, 0, 16'd2);
      put(0, 5'b00000, 0, 8'h00, 8'h21, 1, 0, 0, 0, 16'd2);
      put(0, 5'b00000, 0, 8'h00, 8'h22, 0, 0, 0, 0, 16'd2);
      put(0, 5'b10000, 0, 8'h30, 8'h30, 1, 4, 0, 0, 16'd3);
      put(0, 5'b00011, 0, 8'h00, 8'h31, 1, 0, 1, 0, 16'd3);
      put(0, 5'b00000, 0, 8'h00, 8'h32, 0, 0, 0, 0, 16'd3);
      for (int i = 0; stim_q.size() > 0; i++) begin
         r = stim_q.pop_front(); drive(r); e = exp_q.pop_front(); checks++;
         if ({bus.redirect_cnt, bus.pc, bus.flush, bus.src_idx, bus.pend_vld} !== {e.cnt, e.pc, e.flush, e.src, e.pend}) begin
            errors++;
            $display("FAIL stats[%0d]: got cnt=%0d pc=%h flush=%b src=%0d pend=%b, expected cnt=%0d pc=%h flush=%b src=%0d pend=%b",
                     i, bus.redirect_cnt, bus.pc, bus.flush, bus.src_idx, bus.pend_vld, e.cnt, e.pc, e.flush, e.src, e.pend);
         end
      end
   endtask
`endif

   initial begin
      bus.sel   = 5'b00000;
      bus.stall = 1'b0;
      bus.tgt_a = 8'h00;
      bus.tgt_b = 8'h00;
      bus.tgt_c = 8'h00;
      bus.tgt_d = 8'h00;
      @(posedge clk);
      #1;
      test_reset();
      test_redirect();
      test_stall_pending();
      test_illegal();
      test_wrap();
      test_reset_mid();
`ifdef PCSEL_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
